// File: rtl/alu_pkg.sv
// Purpose: shared opcode encodings, widths and the arbiter state type for the
//          shared ALU slice (alu_core, alu_share_arb).
// Contents:
//   OP_W            opcode width
//   OP_PLUS..OP_NEG legal opcodes; 5..7 are illegal and flagged by alu_core
//   state_t         result-slot state (ST_IDLE / ST_FULL)
package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_PLUS  = 3'd0;
    localparam logic [OP_W-1:0] OP_MINUS = 3'd1;
    localparam logic [OP_W-1:0] OP_AND   = 3'd2;
    localparam logic [OP_W-1:0] OP_OR    = 3'd3;
    localparam logic [OP_W-1:0] OP_NEG   = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Purpose: combinational 8-bit (WIDTH) ALU; the only opcode decoder in the slice.
// Ports:
//   i_opcode  opcode (see alu_pkg)
//   i_a, i_b  operands; i_b ignored for NEG
//   o_result  result, wraps modulo 2^WIDTH; zero for illegal opcodes
//   o_err     high for illegal opcodes (5..7)
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  i_opcode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_err
);

    always_comb begin
        o_result = '0;
        o_err    = 1'b0;
        case (i_opcode)
            OP_PLUS:  o_result = i_a + i_b;
            OP_MINUS: o_result = i_a - i_b;
            OP_AND:   o_result = i_a & i_b;
            OP_OR:    o_result = i_a | i_b;
            OP_NEG:   o_result = ~i_a;
            default:  o_err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Purpose: shares one alu_core between two requesters with round-robin
//          arbitration and a single registered, ID-tagged result slot.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (bit i = requester i)
//   reqN_opcode/_a/_b     requester N operation
//   rsp_valid/rsp_ready   result handshake
//   rsp_id/data/err       requester tag, result, illegal-opcode flag
//   op_count              accepted operations, saturating
//
// state   | meaning
// --------+----------------------------------------------
// ST_IDLE | no result held, rsp_valid=0
// ST_FULL | result held in rsp_* until rsp_ready
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OP_W-1:0]  req0_opcode,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OP_W-1:0]  req1_opcode,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    state_t           r_state;
    logic             r_rr_ptr;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_err;
    logic [CNT_W-1:0] r_op_count;

    logic             w_slot_free;
    logic             w_grant_vld;
    logic             w_grant_id;
    logic [OP_W-1:0]  w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_result;
    logic             w_err;

    // A held result can be replaced on the same edge it is consumed.
    assign w_slot_free = (r_state == ST_IDLE) | rsp_ready;

    // Grant only looks at valids and the pointer, never at operands.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = 1'b0;
        if (!reset && w_slot_free) begin
            case (req_valid)
                2'b01: begin
                    w_grant_vld = 1'b1;
                    w_grant_id  = 1'b0;
                end
                2'b10: begin
                    w_grant_vld = 1'b1;
                    w_grant_id  = 1'b1;
                end
                2'b11: begin
                    w_grant_vld = 1'b1;
                    w_grant_id  = r_rr_ptr;
                end
                default: begin
                    w_grant_vld = 1'b0;
                    w_grant_id  = 1'b0;
                end
            endcase
        end
    end

    assign req_ready = !w_grant_vld ? 2'b00 : (w_grant_id ? 2'b10 : 2'b01);

    assign w_op = w_grant_id ? req1_opcode : req0_opcode;
    assign w_a  = w_grant_id ? req1_a      : req0_a;
    assign w_b  = w_grant_id ? req1_b      : req0_b;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .i_opcode (w_op),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_result (w_result),
        .o_err    (w_err)
    );

    // req_ready is only raised for a valid requester, so a grant is an accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= 1'b0;
            r_rsp_id   <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_op_count <= '0;
        end else if (w_grant_vld) begin
            r_state    <= ST_FULL;
            r_rr_ptr   <= ~w_grant_id;
            r_rsp_id   <= w_grant_id;
            r_rsp_data <= w_result;
            r_rsp_err  <= w_err;
            if (r_op_count != '1) begin
                r_op_count <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (r_state == ST_FULL && rsp_ready) begin
            r_state <= ST_IDLE;
        end
    end

    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [2:0]  req0_opcode, req1_opcode;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [7:0]  rsp_data;
    logic [15:0] op_count;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.WIDTH(8), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req0_opcode (req0_opcode),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_opcode (req1_opcode),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .op_count    (op_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req0_opcode = op; req0_a = a; req0_b = b;
    endtask

    task automatic set1(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req1_opcode = op; req1_a = a; req1_b = b;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [7:0] d,
                           input logic id, input logic e, input logic [15:0] cnt);
        chk({tag, ".valid"}, 32'(rsp_valid), 32'(v));
        chk({tag, ".data"},  32'(rsp_data),  32'(d));
        chk({tag, ".id"},    32'(rsp_id),    32'(id));
        chk({tag, ".err"},   32'(rsp_err),   32'(e));
        chk({tag, ".cnt"},   32'(op_count),  32'(cnt));
    endtask

    initial begin
        reset = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
        set0(OP_PLUS, 8'h00, 8'h00);
        set1(OP_PLUS, 8'h00, 8'h00);
        #1;
        chk("rst_ready_gated", 32'(req_ready), 32'h0);
        tick(); tick();
        chk_rsp("reset", 1'b0, 8'h00, 1'b0, 1'b0, 16'd0);

        // single requester, PLUS
        reset = 1'b0; req_valid = 2'b01; rsp_ready = 1'b1;
        set0(OP_PLUS, 8'h0F, 8'h01);
        #1;
        chk("plus.ready", 32'(req_ready), 32'h1);
        tick();
        chk_rsp("plus", 1'b1, 8'h10, 1'b0, 1'b0, 16'd1);

        set0(OP_MINUS, 8'h00, 8'h01); tick();
        chk_rsp("minus_wrap", 1'b1, 8'hFF, 1'b0, 1'b0, 16'd2);
        set0(OP_PLUS, 8'hFF, 8'h02); tick();
        chk_rsp("plus_wrap", 1'b1, 8'h01, 1'b0, 1'b0, 16'd3);
        set0(OP_NEG, 8'hA5, 8'h33); tick();
        chk_rsp("neg", 1'b1, 8'h5A, 1'b0, 1'b0, 16'd4);

        // idle: valid drops, data holds
        req_valid = 2'b00; tick();
        chk_rsp("idle_hold", 1'b0, 8'h5A, 1'b0, 1'b0, 16'd4);

        // requester 1 alone; leaves the pointer at 0
        req_valid = 2'b10; set1(OP_OR, 8'h0F, 8'hF0); tick();
        chk_rsp("or_r1", 1'b1, 8'hFF, 1'b1, 1'b0, 16'd5);

        // both valid: 0,1,0,1
        req_valid = 2'b11;
        set0(OP_PLUS, 8'h01, 8'h01);
        set1(OP_AND, 8'hFF, 8'h0F);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr%0d.ready", i), 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            chk_rsp($sformatf("rr%0d", i), 1'b1, (i % 2 == 0) ? 8'h02 : 8'h0F,
                    1'((i % 2)), 1'b0, 16'(6 + i));
        end

        // backpressure
        req_valid = 2'b01; set0(OP_PLUS, 8'h10, 8'h20); tick();
        chk_rsp("bp_acc", 1'b1, 8'h30, 1'b0, 1'b0, 16'd10);
        rsp_ready = 1'b0; req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d.ready", i), 32'(req_ready), 32'h0);
            tick();
            chk_rsp($sformatf("bp%0d", i), 1'b1, 8'h30, 1'b0, 1'b0, 16'd10);
        end
        rsp_ready = 1'b1; req_valid = 2'b10; set1(OP_MINUS, 8'h50, 8'h10);
        #1;
        chk("bp_release.ready", 32'(req_ready), 32'h2);
        tick();
        chk_rsp("bp_release", 1'b1, 8'h40, 1'b1, 1'b0, 16'd11);

        // illegal opcode then legal AND
        set1(3'd6, 8'h12, 8'h34); tick();
        chk_rsp("illegal", 1'b1, 8'h00, 1'b1, 1'b1, 16'd12);
        set1(OP_AND, 8'hF0, 8'h3C); tick();
        chk_rsp("and_after", 1'b1, 8'h30, 1'b1, 1'b0, 16'd13);

        // reset while FULL; make the pointer 1 first so reset must clear it
        req_valid = 2'b01; set0(OP_PLUS, 8'h01, 8'h02); tick();
        chk_rsp("pre_rst", 1'b1, 8'h03, 1'b0, 1'b0, 16'd14);
        reset = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
        #1;
        chk("rst_full.ready", 32'(req_ready), 32'h0);
        tick();
        chk_rsp("rst_full", 1'b0, 8'h00, 1'b0, 1'b0, 16'd0);
        reset = 1'b0; rsp_ready = 1'b1;
        set0(OP_OR, 8'h81, 8'h18);
        set1(OP_PLUS, 8'h01, 8'h01);
        #1;
        chk("post_rst.ready", 32'(req_ready), 32'h1);
        tick();
        chk_rsp("post_rst", 1'b1, 8'h99, 1'b0, 1'b0, 16'd1);
        #1;
        chk("post_rst2.ready", 32'(req_ready), 32'h2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one combinational 8-bit ALU core between two requesters through valid/ready handshakes.
- Arbitration is round-robin. The result is registered, tagged with the requester ID, and held under output backpressure.
- Sits between the datapath clients (e.g. address and data units) and the ALU core. It is the single owner of the ALU opcode bus.

Parameters:
- WIDTH, 8, operand/result width.
- CNT_W, 16, width of the saturating operation counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  2  per-requester request valid (bit i = requester i)
- req_ready  output  2  per-requester accept (bit i = requester i)
- req0_opcode  input  3  requester 0 ALU opcode
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- req1_opcode  input  3  requester 1 ALU opcode
- req1_a  input  WIDTH  requester 1 operand A
- req1_b  input  WIDTH  requester 1 operand B
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  1  requester that issued the result
- rsp_data  output  WIDTH  registered ALU result
- rsp_err  output  1  opcode was illegal (5..7)
- op_count  output  CNT_W  accepted operations, saturating at all-ones

Behaviour:
- Reset is synchronous: while reset=1, the next edge sets rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, op_count=0, rr_ptr=0 and state=IDLE. req_ready=2'b00 whenever reset=1 (combinational gating).
- Opcodes:
  - 0 PLUS: a+b
  - 1 MINUS: a-b
  - 2 AND: a&b
  - 3 OR: a|b
  - 4 NEG: ~a, b ignored
  - 5..7: data=0, rsp_err=1
- Arithmetic wraps modulo 2^WIDTH; carry and borrow are discarded.
- States:
  - IDLE: no result held.
  - FULL: rsp_valid=1, result held.
- Slot free: slot_free = (state==IDLE) | rsp_ready.
- Grant (combinational, only when slot_free):
  - If only one requester is valid, it is granted.
  - If both are valid, rr_ptr chooses: 0 grants requester 0, 1 grants requester 1.
  - At most one req_ready bit is ever high. req_ready does not depend on the granted requester's own opcode or operands.
- Accept: req_valid[i] & req_ready[i] at an edge. On that edge:
  - rsp_data, rsp_err and rsp_id are loaded from the ALU core output.
  - state goes to FULL.
  - rr_ptr becomes the opposite of the granted ID (applies even when only one requester was valid).
  - op_count increments unless already all-ones.
- Latency: accept at edge N gives rsp_valid=1 after edge N.
- Throughput: 1 op/cycle when rsp_ready is held high; a new accept and a consume may occur on the same edge.
- FULL, rsp_ready=0: rsp_valid, rsp_data, rsp_id and rsp_err are stable; req_ready=00.
- FULL, rsp_ready=1, no accept: next state is IDLE and rsp_valid drops to 0.
- IDLE, no accept: outputs hold their last values; rsp_valid=0.
- A requester deasserting req_valid without a handshake is legal and leaves no state behind.
- Reset asserted mid-operation (FULL) discards the held result; nothing is accepted on that edge.

Decomposition:
- Package alu_pkg:
  - localparams OP_PLUS=3'd0, OP_MINUS=3'd1, OP_AND=3'd2, OP_OR=3'd3, OP_NEG=3'd4.
  - Opcode width 3; state encoding IDLE/FULL.
- Sub-module alu_core (combinational; opcode, a, b -> result, err) is instantiated once. It is the only place opcode decode lives.
- Arbiter, state register and counter stay in the top module.

Test Plan:
- Reset, then req0 only: PLUS 8'h0F+8'h01, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=8'h10, rsp_id=0, rsp_err=0, op_count=1.
- Wrap and NEG: MINUS 8'h00-8'h01 -> 8'hFF; PLUS 8'hFF+8'h02 -> 8'h01; NEG a=8'hA5 -> 8'h5A.
- Both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 (rr_ptr starts 0); rsp_id sequence 0,1,0,1; one grant per cycle.
- Backpressure: rsp_ready=0 for 3 cycles after an accept -> req_ready=00 and rsp_* stable for those 3 cycles. Raising rsp_ready with req1 valid gives consume and accept on the same edge, with no bubble.
- Illegal opcode 3'd6 from req1 -> rsp_data=8'h00, rsp_err=1, rsp_id=1; the next legal AND 8'hF0&8'h3C -> 8'h30, rsp_err=0.
- Reset asserted while FULL -> next cycle rsp_valid=0, op_count=0, rr_ptr=0. With both requesters valid afterwards, requester 0 is granted first.
